// File: rtl/barrel_shift_arbiter.sv
// -----------------------------------------------------------------------------
// barrel_shift_arbiter
//
// Purpose:
//   Shares one external combinational left/right barrel shifter between NREQ
//   requesters. One requester is granted at a time. Its operand, shift amount
//   and direction are registered onto the shifter inputs. The shifter output
//   is captured one cycle later and returned with the owner's index. A
//   grant/execute/done sequence means operations never overlap.
//
// Configuration:
//   SHIFT_ARB_FIXED_PRIO_EN  defined     : fixed priority, lowest index wins,
//                                          and no round-robin pointer exists.
//                            not defined : round-robin. The search starts at
//                                          the pointer and wraps NREQ-1 -> 0.
//
// Parameters:
//   WIDTH  operand width (power of 2, >= 4)
//   NREQ   number of requesters (2..8)
//   AW     shift-amount width, log2(WIDTH)
//   IW     requester-id width, log2(NREQ)
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        per-requester request valid
//   req_ready  out  [NREQ]        one-hot grant, only in the grant cycle
//   req_data   in   [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_amt    in   [NREQ*AW]     shift amounts, requester i at [i*AW +: AW]
//   req_dir    in   [NREQ]        0 = left, 1 = right
//   sh_in      out  [WIDTH]       registered operand to the shifter
//   sh_sel     out  [AW]          registered shift amount to the shifter
//   sh_dir     out                registered direction to the shifter
//   sh_out     in   [WIDTH]       shifter result, combinational from sh_*
//   res_valid  out                result valid
//   res_ready  in                 result consumer ready
//   res_data   out  [WIDTH]       captured shifter result
//   res_id     out  [IW]          requester index that owns res_data
// -----------------------------------------------------------------------------
module barrel_shift_arbiter #(
   parameter  int WIDTH = 4,
   parameter  int NREQ  = 4,
   localparam int AW    = $clog2(WIDTH),
   localparam int IW    = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ*AW-1:0]    req_amt,
   input  logic [NREQ-1:0]       req_dir,
   output logic [WIDTH-1:0]      sh_in,
   output logic [AW-1:0]         sh_sel,
   output logic                  sh_dir,
   input  logic [WIDTH-1:0]      sh_out,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_data,
   output logic [IW-1:0]         res_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [WIDTH-1:0] data_arr [NREQ];
   logic [AW-1:0]    amt_arr  [NREQ];

   logic             any_valid;
   logic [IW-1:0]    gnt_idx;
   logic             grant;
   logic [IW-1:0]    id_q;

   // Split the flat request buses into per-requester fields. The grant mux
   // can then index by requester number.
   // NOTE: every combinational output gets a default at the top of the block,
   // so no path can leave it unassigned and infer a latch.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = req_data[i*WIDTH +: WIDTH];
         amt_arr[i]  = req_amt[i*AW +: AW];
      end
   end

`ifdef SHIFT_ARB_FIXED_PRIO_EN

   // Fixed priority. The scan runs from the highest index down, so the lowest
   // valid index is written last and wins.
   always_comb begin
      any_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            any_valid = 1'b1;
            gnt_idx   = IW'(i);
         end
      end
   end

`else

   logic [IW-1:0] ptr_q;

   // Round-robin. The search offset k = 0 maps to the pointer. The scan runs
   // from the largest offset down, so the requester nearest the pointer
   // (mod NREQ) is written last and wins. The explicit subtraction wraps the
   // index for NREQ values that are not a power of two.
   always_comb begin
      int idx;
      any_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req_valid[idx]) begin
            any_valid = 1'b1;
            gnt_idx   = IW'(idx);
         end
      end
   end

   // The pointer moves to the slot just after the winner, so the winner has
   // the lowest priority for the next search.
   // NOTE: clocked state uses non-blocking assignments. All flops then sample
   // pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (grant) begin
         ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

`endif

   // A grant happens only in IDLE. req_ready depends on req_valid, state and
   // pointer only, and nothing feeds req_ready back into the arbiter.
   assign grant = (state_q == IDLE) && any_valid;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
   end

   // --------------------------------------------------------------------------
   // Sequencing FSM: IDLE -> EXEC (shifter settles) -> DONE (hold result).
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_valid) state_d = EXEC;
         EXEC:    state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Shifter input registers. They load only on a grant, so the shifter sees
   // the last granted operation until the next grant.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_in  <= '0;
         sh_sel <= '0;
         sh_dir <= 1'b0;
         id_q   <= '0;
      end else if (grant) begin
         sh_in  <= data_arr[gnt_idx];
         sh_sel <= amt_arr[gnt_idx];
         sh_dir <= req_dir[gnt_idx];
         id_q   <= gnt_idx;
      end
   end

   // --------------------------------------------------------------------------
   // Result registers. The shifter output is captured at the end of EXEC, when
   // sh_* has been stable for one full cycle. The result is held until the
   // consumer takes it.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
      end else begin
         if (state_q == EXEC) begin
            res_valid <= 1'b1;
            res_data  <= sh_out;
            res_id    <= id_q;
         end else if ((state_q == DONE) && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_barrel_shift_arbiter
//
// Purpose:
//   Self-checking bench for barrel_shift_arbiter (WIDTH = 4, NREQ = 4). The
//   shared shifter is a bit-level rotate model driven from sh_*. A cycle model
//   at transaction level predicts grants, result timing, result contents and
//   the shifter input registers every cycle. Expected results are computed
//   from the requester's own operand with a different rotate formulation.
//   Directed phases cover reset, a single request, round-robin order, pointer
//   wrap, backpressure and reset during DONE. A randomized phase follows.
//   Honours SHIFT_ARB_FIXED_PRIO_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_barrel_shift_arbiter;

   localparam int WIDTH = 4;
   localparam int NREQ  = 4;
   localparam int AW    = $clog2(WIDTH);
   localparam int IW    = $clog2(NREQ);

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ*AW-1:0]    req_amt;
   logic [NREQ-1:0]       req_dir;
   logic [WIDTH-1:0]      sh_in;
   logic [AW-1:0]         sh_sel;
   logic                  sh_dir;
   logic [WIDTH-1:0]      sh_out;
   logic                  res_valid;
   logic                  res_ready;
   logic [WIDTH-1:0]      res_data;
   logic [IW-1:0]         res_id;

   int n_checks;
   int n_errors;

   barrel_shift_arbiter #(
      .WIDTH (WIDTH),
      .NREQ  (NREQ)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .req_dir   (req_dir),
      .sh_in     (sh_in),
      .sh_sel    (sh_sel),
      .sh_dir    (sh_dir),
      .sh_out    (sh_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Shared shifter modelled bit by bit as a rotate, like the mux slices.
   function automatic logic [WIDTH-1:0] shifter_model(input logic [WIDTH-1:0] x,
                                                      input logic [AW-1:0]    a,
                                                      input logic             right);
      logic [WIDTH-1:0] y;
      y = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (right) y[i] = x[(i + int'(a)) % WIDTH];
         else       y[i] = x[(i - int'(a) + WIDTH) % WIDTH];
      end
      return y;
   endfunction

   assign sh_out = shifter_model(sh_in, sh_sel, sh_dir);

   // Reference rotate with a double-width shift, independent of the bit model.
   function automatic logic [WIDTH-1:0] ref_rot(input logic [WIDTH-1:0] x,
                                                input int               a,
                                                input logic             right);
      logic [2*WIDTH-1:0] d;
      d = {x, x};
      if (right) begin
         d = d >> a;
         return d[WIDTH-1:0];
      end
      d = d << a;
      return d[2*WIDTH-1:WIDTH];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Transaction-level reference model.
   // ---------------------------------------------------------------------------
   bit               m_busy;
   int               m_grant_cyc;
   logic [WIDTH-1:0] m_exp_data;
   int               m_exp_id;
   logic [WIDTH-1:0] m_sh_in;
   logic [AW-1:0]    m_sh_sel;
   logic             m_sh_dir;
   logic [NREQ-1:0]  m_gnt_mask;
   int               cyc;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
   int               m_ptr;
`endif

   logic [NREQ-1:0]  s_ready;
   logic             s_rv;
   logic [WIDTH-1:0] s_data;
   logic [IW-1:0]    s_id;
   logic [WIDTH-1:0] s_sh_in;
   logic [NREQ-1:0]  exp_mask;

   task automatic model_reset();
      m_busy      = 1'b0;
      m_grant_cyc = 0;
      m_exp_data  = '0;
      m_exp_id    = 0;
      m_sh_in     = '0;
      m_sh_sel    = '0;
      m_sh_dir    = 1'b0;
      m_gnt_mask  = '0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      m_ptr       = 0;
`endif
   endtask

   // Winner among v, or -1 if none.
   function automatic int pick(input logic [NREQ-1:0] v);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] m;
      m    = '0;
      m[i] = 1'b1;
      return m;
   endfunction

   task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [AW-1:0] a,
                          input logic dir);
      req_data[i*WIDTH +: WIDTH] = d;
      req_amt[i*AW +: AW]        = a;
      req_dir[i]                 = dir;
   endtask

   // One clock cycle. Inputs are already driven (posedge + 1). The task
   // samples and checks at the negedge, advances the model, and returns at
   // the next posedge + 1.
   task automatic step();
      int              w;
      logic [NREQ-1:0] e_ready;
      logic            e_rv;
      @(negedge clk);
      s_ready = req_ready;
      s_rv    = res_valid;
      s_data  = res_data;
      s_id    = res_id;
      s_sh_in = sh_in;
      e_ready = '0;
      w       = -1;
      if (!m_busy) begin
         w = pick(req_valid);
         if (w >= 0) e_ready = onehot(w);
      end
      e_rv = m_busy && ((cyc - m_grant_cyc) >= 2);
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("res_valid", 32'(res_valid), 32'(e_rv));
      if (e_rv) begin
         check("res_data", 32'(res_data), 32'(m_exp_data));
         check("res_id", 32'(res_id), 32'(m_exp_id));
      end
      check("sh_in", 32'(sh_in), 32'(m_sh_in));
      check("sh_sel", 32'(sh_sel), 32'(m_sh_sel));
      check("sh_dir", 32'(sh_dir), 32'(m_sh_dir));
      if (w >= 0) begin
         m_busy      = 1'b1;
         m_grant_cyc = cyc;
         m_sh_in     = req_data[w*WIDTH +: WIDTH];
         m_sh_sel    = req_amt[w*AW +: AW];
         m_sh_dir    = req_dir[w];
         m_exp_data  = ref_rot(m_sh_in, int'(m_sh_sel), m_sh_dir);
         m_exp_id    = w;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
         m_ptr       = (w + 1) % NREQ;
`endif
      end else if (e_rv && res_ready) begin
         m_busy = 1'b0;
      end
      m_gnt_mask = e_ready;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Random requesters that obey the hold rule: a pending, ungranted request
   // keeps its payload and may only be withdrawn.
   task automatic rand_drive();
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && !m_gnt_mask[i]) begin
            if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            set_req(i, WIDTH'($urandom), AW'($urandom), 1'($urandom));
         end else begin
            req_valid[i] = 1'b0;
         end
      end
      res_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 0);
      check({tag, "_sh_in"}, 32'(sh_in), 0);
      check({tag, "_sh_sel"}, 32'(sh_sel), 0);
      check({tag, "_sh_dir"}, 32'(sh_dir), 0);
      check({tag, "_res_valid"}, 32'(res_valid), 0);
      check({tag, "_res_data"}, 32'(res_data), 0);
      check({tag, "_res_id"}, 32'(res_id), 0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      cyc       = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_amt   = '0;
      req_dir   = '0;
      res_ready = 1'b0;
      model_reset();

      // Reset values.
      #3;
      check_all_zero("rst");
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All requesters valid continuously: one grant every 3 cycles.
      for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'(i + 5), AW'(i), 1'(i & 1));
      req_valid = '1;
      res_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         exp_mask = '0;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
         if (k % 3 == 0) exp_mask = onehot(0);
`else
         if (k % 3 == 0) exp_mask = onehot((k / 3) % NREQ);
`endif
         check("rr_grant", 32'(s_ready), 32'(exp_mask));
      end
      req_valid = '0;
      step();
      check("idle_no_req", 32'(s_ready), 0);

      // Single request: req 2, 1011 rotated left by 1.
      set_req(2, 4'b1011, 2'd1, 1'b0);
      req_valid[2] = 1'b1;
      step();
      check("single_grant", 32'(s_ready), 32'(4'b0100));
      req_valid = '0;
      step();
      check("single_exec_rv", 32'(s_rv), 0);
      check("single_sh_in", 32'(s_sh_in), 32'(4'b1011));
      step();
      check("single_rv", 32'(s_rv), 1);
      check("single_data", 32'(s_data), 32'(4'b0111));
      check("single_id", 32'(s_id), 2);

      // Pointer wrap: pointer 3, only req 1 valid. Req 1 wins, pointer -> 2.
      req_valid[1] = 1'b1;
      step();
      check("wrap_grant", 32'(s_ready), 32'(4'b0010));
      req_valid = '0;
      step();
      step();
      set_req(0, 4'b0001, 2'd2, 1'b0);
      set_req(2, 4'b1101, 2'd3, 1'b1);
      req_valid = '1;
      res_ready = 1'b0;
      step();
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      check("wrap_next_grant", 32'(s_ready), 32'(4'b0001));
`else
      check("wrap_next_grant", 32'(s_ready), 32'(4'b0100));
`endif

      // Backpressure: result held stable and no grants while res_ready is low.
      step();
      for (int k = 0; k < 6; k++) begin
         step();
         check("bp_rv", 32'(s_rv), 1);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
         check("bp_data", 32'(s_data), 32'(4'b0100));
         check("bp_id", 32'(s_id), 0);
`else
         check("bp_data", 32'(s_data), 32'(4'b1011));
         check("bp_id", 32'(s_id), 2);
`endif
         check("bp_ready", 32'(s_ready), 0);
      end
      res_ready = 1'b1;
      step();
      check("bp_release_rv", 32'(s_rv), 1);
      step();
      check("bp_release_rv_drop", 32'(s_rv), 0);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      check("bp_next_grant", 32'(s_ready), 32'(4'b0001));
`else
      check("bp_next_grant", 32'(s_ready), 32'(4'b1000));
`endif
      req_valid = '0;
      step();
      step();

      // Randomized traffic against the model.
      for (int k = 0; k < 600; k++) begin
         rand_drive();
         step();
      end
      req_valid = '0;
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) step();

      // Reset asserted mid-DONE with a result pending.
      set_req(1, 4'b0110, 2'd1, 1'b1);
      req_valid[1] = 1'b1;
      res_ready    = 1'b0;
      step();
      check("mr_grant", 32'(s_ready), 32'(4'b0010));
      req_valid = '0;
      step();
      step();
      check("mr_rv", 32'(s_rv), 1);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("mr");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      req_valid = '1;
      res_ready = 1'b1;
      step();
      check("post_reset_grant", 32'(s_ready), 32'(4'b0001));
      req_valid = '0;
      step();
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
